// File: rtl/pkt_ctrl_arb_if.sv
// Bundle of request, engine-handshake and status signals for pkt_ctrl_arb.
// The slave modport is the arbiter side; the master modport is the requester/engine side.
interface pkt_ctrl_arb_if #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH),
  parameter int CNT_W  = 16
);
  // Handshake: rd_ctrl/wr_ctrl act as "valid" and stay high until the engine
  // answers with a one-cycle *_rdy; rd_ctrl_rdy must come before (or with) wr_ctrl_rdy.
  logic [NUM_CH-1:0] req;
  logic              rd_ctrl_rdy;
  logic              wr_ctrl_rdy;
  logic              rd_ctrl;
  logic              wr_ctrl;
  logic [CH_W-1:0]   ch_sel;
  logic              busy;
  logic              done;
  logic [CH_W-1:0]   done_ch;
  logic              timeout;
  logic [2:0]        state_out;
  logic [CNT_W-1:0]  pkt_cnt;

  modport master (
    output req, rd_ctrl_rdy, wr_ctrl_rdy,
    input  rd_ctrl, wr_ctrl, ch_sel, busy, done, done_ch, timeout, state_out, pkt_cnt
  );

  modport slave (
    input  req, rd_ctrl_rdy, wr_ctrl_rdy,
    output rd_ctrl, wr_ctrl, ch_sel, busy, done, done_ch, timeout, state_out, pkt_cnt
  );
endinterface

// File: rtl/pkt_ctrl_arb.sv
// Round-robin packet controller: grants one channel at a time to the read/write engines.
// Optional watchdog enabled by defining PKT_CTRL_TIMEOUT_EN.
module pkt_ctrl_arb #(
  parameter int NUM_CH      = 4,
  parameter int CH_W        = $clog2(NUM_CH),
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic          clk,
  input logic          reset,
  pkt_ctrl_arb_if.slave bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ARB     = 3'd1;
  localparam logic [2:0] RUN     = 3'd2;
  localparam logic [2:0] RD_DONE = 3'd3;
  localparam logic [2:0] WR_DONE = 3'd4;
  localparam logic [2:0] ERR     = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [CH_W-1:0]   last_grant_q, last_grant_d;
  logic [CH_W-1:0]   ch_sel_q, ch_sel_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CH_W-1:0]   done_ch_q, done_ch_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;

  logic              grant_found;
  logic [CH_W-1:0]   grant_idx;
  int                idx;

`ifdef PKT_CTRL_TIMEOUT_EN
  // The transfer times out on the busy cycle where the count would reach TIMEOUT_CYC-1.
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 2);
  logic [15:0] wdog_q, wdog_d;
`endif

  // Rotating priority search starting just after the last granted channel.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(last_grant_q) + k) % NUM_CH;
      if (!grant_found && pending_q[idx]) begin
        grant_found = 1'b1;
        grant_idx   = CH_W'(idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q | bus.req;
    last_grant_d = last_grant_q;
    ch_sel_d     = ch_sel_q;
    case (state_q)
      IDLE:    if ((pending_q | bus.req) != '0) state_d = ARB;
      ARB: begin
        if (grant_found) begin
          state_d      = RUN;
          ch_sel_d     = grant_idx;
          last_grant_d = grant_idx;
          // A request arriving on the grant cycle re-pends the channel.
          pending_d    = (pending_q & ~(NUM_CH'(1) << grant_idx)) | bus.req;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (bus.rd_ctrl_rdy && bus.wr_ctrl_rdy) state_d = WR_DONE;
        else if (bus.rd_ctrl_rdy)               state_d = RD_DONE;
      end
      RD_DONE: if (bus.wr_ctrl_rdy) state_d = WR_DONE;
      WR_DONE, ERR: state_d = ((pending_q | bus.req) != '0) ? ARB : IDLE;
      default: state_d = IDLE;
    endcase

    timeout_d = 1'b0;
`ifdef PKT_CTRL_TIMEOUT_EN
    wdog_d = '0;
    if (state_q == RUN || state_q == RD_DONE) begin
      wdog_d = wdog_q + 16'd1;
      if (state_d != WR_DONE && wdog_q == WD_LAST) state_d = ERR;
    end
    timeout_d = (state_d == ERR);
`endif

    busy_d    = (state_d != IDLE);
    done_d    = (state_d == WR_DONE);
    done_ch_d = (state_d == WR_DONE) ? ch_sel_q : done_ch_q;
    pkt_cnt_d = pkt_cnt_q;
    if (state_d == WR_DONE && pkt_cnt_q != '1) pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      last_grant_q <= CH_W'(NUM_CH - 1);
      ch_sel_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      done_ch_q    <= '0;
      timeout_q    <= 1'b0;
      pkt_cnt_q    <= '0;
`ifdef PKT_CTRL_TIMEOUT_EN
      wdog_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      ch_sel_q     <= ch_sel_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      done_ch_q    <= done_ch_d;
      timeout_q    <= timeout_d;
      pkt_cnt_q    <= pkt_cnt_d;
`ifdef PKT_CTRL_TIMEOUT_EN
      wdog_q       <= wdog_d;
`endif
    end
  end

  // Engine enables decode the current state only, so reset drops them immediately.
  assign bus.rd_ctrl   = (state_q == RUN);
  assign bus.wr_ctrl   = (state_q == RUN) || (state_q == RD_DONE);
  assign bus.ch_sel    = ch_sel_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.done_ch   = done_ch_q;
  assign bus.timeout   = timeout_q;
  assign bus.state_out = state_q;
  assign bus.pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_pkt_ctrl_arb.sv
// Self-checking bench for pkt_ctrl_arb: directed scenarios plus random request batches
// checked against a rotating-priority grant model and a saturating transfer count.
module tb_pkt_ctrl_arb;
  localparam int NUM_CH      = 4;
  localparam int CH_W        = 2;
  localparam int CNT_W       = 2;
  localparam int TIMEOUT_CYC = 8;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARB     = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_RD_DONE = 3'd3;
  localparam logic [2:0] S_WR_DONE = 3'd4;
  localparam logic [2:0] S_ERR     = 3'd5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   last_grant;
  int   exp_cnt;
  logic [CH_W-1:0] exp_q[$];

  pkt_ctrl_arb_if #(.NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(CNT_W)) bus ();

  pkt_ctrl_arb #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1, "time limit");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Holds reset for two cycles with requests active (they must be ignored).
  task automatic do_reset;
    reset = 1'b0;
    bus.req = '1;
    tick;
    tick;
    chk("rst_state", bus.state_out, S_IDLE);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rd_ctrl", bus.rd_ctrl, 0);
    chk("rst_wr_ctrl", bus.wr_ctrl, 0);
    chk("rst_ch_sel", bus.ch_sel, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_done_ch", bus.done_ch, 0);
    chk("rst_timeout", bus.timeout, 0);
    chk("rst_pkt_cnt", bus.pkt_cnt, 0);
    bus.req = '0;
    reset = 1'b1;
    tick;
    chk("rst_req_ignored", bus.state_out, S_IDLE);
    last_grant = NUM_CH - 1;
    exp_cnt = 0;
  endtask

  task automatic pulse_req(input logic [NUM_CH-1:0] mask);
    bus.req = mask;
    tick;
    bus.req = '0;
    chk("pulse_to_arb", bus.state_out, S_ARB);
  endtask

  task automatic wait_run;
    int n = 0;
    while (bus.rd_ctrl !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    chk("wait_rd_ctrl", 32'(n < 20), 1);
  endtask

  // driver: one transfer from RUN entry through the done pulse
  task automatic serve(input int ch, input int rd_lat, input int wr_lat, input logic [2:0] next_st);
    wait_run();
    chk("ch_sel", bus.ch_sel, ch);
    chk("busy_run", bus.busy, 1);
    chk("run_wr_ctrl", bus.wr_ctrl, 1);
    for (int i = 0; i < rd_lat; i++) begin
      bus.wr_ctrl_rdy = 1'($urandom_range(0, 1));
      tick;
      bus.wr_ctrl_rdy = 1'b0;
      chk("run_hold", bus.state_out, S_RUN);
    end
    bus.rd_ctrl_rdy = 1'b1;
    bus.wr_ctrl_rdy = (wr_lat == 0);
    tick;
    bus.rd_ctrl_rdy = 1'b0;
    bus.wr_ctrl_rdy = 1'b0;
    if (wr_lat > 0) begin
      chk("rd_done_state", bus.state_out, S_RD_DONE);
      chk("rd_done_rd_ctrl", bus.rd_ctrl, 0);
      chk("rd_done_wr_ctrl", bus.wr_ctrl, 1);
      for (int i = 0; i < wr_lat - 1; i++) begin
        tick;
        chk("rd_done_hold", bus.state_out, S_RD_DONE);
      end
      bus.wr_ctrl_rdy = 1'b1;
      tick;
      bus.wr_ctrl_rdy = 1'b0;
    end
    exp_cnt = (exp_cnt >= CNT_MAX) ? CNT_MAX : exp_cnt + 1;
    chk("wr_done_state", bus.state_out, S_WR_DONE);
    chk("done", bus.done, 1);
    chk("done_ch", bus.done_ch, ch);
    chk("pkt_cnt", bus.pkt_cnt, exp_cnt);
    tick;
    chk("after_done_state", bus.state_out, next_st);
    chk("done_one_cycle", bus.done, 0);
    last_grant = ch;
  endtask

  initial begin
    logic [NUM_CH-1:0] mask;
    int ch;
    bus.req = '0;
    bus.rd_ctrl_rdy = 1'b0;
    bus.wr_ctrl_rdy = 1'b0;
    last_grant = NUM_CH - 1;
    exp_cnt = 0;

    do_reset();

    // single request on channel 2, rd after 3 cycles, wr 2 cycles later
    pulse_req(4'b0100);
    serve(2, 3, 2, S_IDLE);

    // rd and wr ready together on the first RUN cycle skips RD_DONE
    pulse_req(4'b0001);
    serve(0, 0, 0, S_IDLE);

    // engine never answers: watchdog (if built in) must abort without counting
    pulse_req(4'b0010);
    for (int i = 0; i < TIMEOUT_CYC - 1; i++) begin
      tick;
      chk("to_run", bus.state_out, S_RUN);
    end
`ifdef PKT_CTRL_TIMEOUT_EN
    tick;
    chk("to_err_state", bus.state_out, S_ERR);
    chk("to_pulse", bus.timeout, 1);
    chk("to_no_done", bus.done, 0);
    chk("to_pkt_cnt", bus.pkt_cnt, exp_cnt);
    tick;
    chk("to_after_state", bus.state_out, S_IDLE);
    chk("to_pulse_end", bus.timeout, 0);
`else
    for (int i = 0; i < 20; i++) tick;
    chk("no_to_stays_run", bus.state_out, S_RUN);
    chk("no_to_timeout", bus.timeout, 0);
`endif
    do_reset();

    // reset while in RD_DONE aborts with no done pulse
    pulse_req(4'b0001);
    wait_run();
    bus.rd_ctrl_rdy = 1'b1;
    tick;
    bus.rd_ctrl_rdy = 1'b0;
    chk("abort_in_rd_done", bus.state_out, S_RD_DONE);
    reset = 1'b0;
    tick;
    chk("abort_state", bus.state_out, S_IDLE);
    chk("abort_rd_ctrl", bus.rd_ctrl, 0);
    chk("abort_wr_ctrl", bus.wr_ctrl, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_pkt_cnt", bus.pkt_cnt, 0);
    reset = 1'b1;
    tick;
    chk("abort_no_done_after", bus.done, 0);
    last_grant = NUM_CH - 1;
    exp_cnt = 0;

    // all channels held: strict rotation with no IDLE gap, count saturates
    bus.req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      ch = (last_grant + 1) % NUM_CH;
      serve(ch, $urandom_range(0, 1), $urandom_range(0, 1), S_ARB);
    end
    bus.req = '0;
    do_reset();

    // random batches: pulsed mask served in rotating order from last grant
    for (int b = 0; b < 12; b++) begin
      chk("batch_idle", bus.state_out, S_IDLE);
      mask = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
      for (int k = 1; k <= NUM_CH; k++) begin
        ch = (last_grant + k) % NUM_CH;
        if (mask[ch]) exp_q.push_back(CH_W'(ch));
      end
      pulse_req(mask);
      while (exp_q.size() > 0) begin
        ch = int'(exp_q.pop_front());
        serve(ch, $urandom_range(0, 2), $urandom_range(0, 2),
              (exp_q.size() > 0) ? S_ARB : S_IDLE);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
